// File: rtl/mm_result_drain_buffer_pkg.sv
// Shared constants, FSM encoding and write-path helpers for the MXU result drain buffer.
// Optional feature macro: MM_DRAIN_RELU_EN (zero negative int8 bytes on the write path).
package mm_result_drain_buffer_pkg;

  localparam int ROWS        = 16;
  localparam int LANE_W      = 8;
  localparam int ADDR_W      = 8;
  localparam int BYTE_ADDR_W = 12;
  localparam int MASK_W      = 16;
  localparam int LINE_W      = ROWS * LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } drain_state_e;

  // Shift a packed row up by off bytes (spilled bytes fall off the top), then optionally clamp negatives.
  function automatic logic [LINE_W-1:0] align_row(input logic [LINE_W-1:0] row, input logic [3:0] off);
    logic [LINE_W-1:0] shifted;
    shifted = row << {off, 3'b000};
`ifdef MM_DRAIN_RELU_EN
    for (int b = 0; b < MASK_W; b++) begin
      if (shifted[b*LANE_W + LANE_W - 1]) begin
        shifted[b*LANE_W +: LANE_W] = 8'h00;
      end else begin
        shifted[b*LANE_W +: LANE_W] = shifted[b*LANE_W +: LANE_W];
      end
    end
`endif
    return shifted;
  endfunction

  function automatic logic [MASK_W-1:0] byte_mask(input logic [3:0] col_len, input logic [3:0] off);
    return (16'hFFFF >> (4'd15 - col_len)) << off;
  endfunction

endpackage

// File: rtl/mm_result_drain_buffer_row_pack.sv
// One row entry: collects the bytes of a single MXU lane in column order until the row is complete.
module mm_result_drain_buffer_row_pack
  import mm_result_drain_buffer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              vld_i,
  input  logic [LANE_W-1:0] byte_i,
  input  logic [3:0]        col_len_i,
  output logic [LINE_W-1:0] row_o,
  output logic              row_done_o,
  output logic              overflow_o
);

  logic [ROWS-1:0][LANE_W-1:0] bytes_q;
  logic [3:0]                  col_cnt_q;
  logic                        done_q;

  // Byte capture, column counter and completion flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bytes_q   <= '0;
      col_cnt_q <= 4'd0;
      done_q    <= 1'b0;
    end else if (clear_i) begin
      bytes_q   <= '0;
      col_cnt_q <= 4'd0;
      done_q    <= 1'b0;
    end else if (vld_i && !done_q) begin
      bytes_q[col_cnt_q] <= byte_i;
      col_cnt_q          <= col_cnt_q + 4'd1;
      done_q             <= (col_cnt_q == col_len_i);
    end else begin
      done_q <= done_q;
    end
  end

  assign row_o      = bytes_q;
  assign row_done_o = done_q;
  assign overflow_o = vld_i && done_q;

endmodule

// File: rtl/mm_result_drain_buffer.sv
// MXU result drain: de-skews per-lane results into rows and writes each row to RAM as one line.
// Optional feature macro: MM_DRAIN_RELU_EN (handled inside the package write-path helper).
module mm_result_drain_buffer
  import mm_result_drain_buffer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lsu_mm_drain_ctrl_vld,
  input  logic [3:0]             lsu_mm_drain_ctrl_row_len,
  input  logic [3:0]             lsu_mm_drain_ctrl_col_len,
  input  logic [BYTE_ADDR_W-1:0] lsu_mm_drain_ctrl_start_addr,
  input  logic [ROWS-1:0]        mxu_mm_drain_vld,
  input  logic [LINE_W-1:0]      mxu_mm_drain_data,
  output logic                   lsu_mm_drain_ram_write_vld,
  input  logic                   lsu_mm_drain_ram_write_rdy,
  output logic [ADDR_W-1:0]      lsu_mm_drain_ram_write_addr,
  output logic [LINE_W-1:0]      lsu_mm_drain_ram_write_data,
  output logic [MASK_W-1:0]      lsu_mm_drain_ram_write_mask,
  output logic                   lsu_mm_drain_busy,
  output logic                   lsu_mm_drain_done,
  output logic                   lsu_mm_drain_err
);

  drain_state_e           state_q, state_d;
  logic [3:0]             row_len_q, row_len_d;
  logic [3:0]             col_len_q, col_len_d;
  logic [BYTE_ADDR_W-1:0] start_q, start_d;
  logic [3:0]             ptr_q, ptr_d;
  logic                   wr_vld_q, wr_vld_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [LINE_W-1:0]      wr_data_q, wr_data_d;
  logic [MASK_W-1:0]      wr_mask_q, wr_mask_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   clear_s;
  logic                   load_s;
  logic [3:0]             load_idx_s;
  logic                   spill_s;
  logic                   lane_err_s;
  logic [ROWS-1:0]        lane_en_s;
  logic [ROWS-1:0]        lane_vld_s;
  logic [ROWS-1:0]        row_done_s;
  logic [ROWS-1:0]        ovf_s;
  logic [LINE_W-1:0]      pack_row_s [ROWS];

  always_comb begin
    lane_en_s  = '0;
    lane_vld_s = '0;
    for (int i = 0; i < ROWS; i++) begin
      lane_en_s[i]  = (5'(i) <= {1'b0, row_len_q});
      lane_vld_s[i] = (state_q == ST_RUN) && mxu_mm_drain_vld[i] && lane_en_s[i];
    end
  end

  for (genvar g = 0; g < ROWS; g++) begin : g_pack
    mm_result_drain_buffer_row_pack u_pack (
      .clk_i      (clk),
      .rst_i      (rst),
      .clear_i    (clear_s),
      .vld_i      (lane_vld_s[g]),
      .byte_i     (mxu_mm_drain_data[g*LANE_W +: LANE_W]),
      .col_len_i  (col_len_q),
      .row_o      (pack_row_s[g]),
      .row_done_o (row_done_s[g]),
      .overflow_o (ovf_s[g])
    );
  end

  assign spill_s = ({1'b0, lsu_mm_drain_ctrl_start_addr[3:0]} + {1'b0, lsu_mm_drain_ctrl_col_len}) > 5'd15;

  // Lane traffic outside RUN, on disabled lanes, or after a row completed is dropped and flagged
  always_comb begin
    if (state_q == ST_RUN) begin
      lane_err_s = |(mxu_mm_drain_vld & ~lane_en_s) | (|ovf_s);
    end else begin
      lane_err_s = |mxu_mm_drain_vld;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_len_d  = row_len_q;
    col_len_d  = col_len_q;
    start_d    = start_q;
    ptr_d      = ptr_q;
    wr_vld_d   = wr_vld_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_mask_d  = wr_mask_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    clear_s    = 1'b0;
    load_s     = 1'b0;
    load_idx_s = ptr_q;
    err_d      = lane_err_s
               | (lsu_mm_drain_ctrl_vld && (state_q != ST_IDLE))
               | (lsu_mm_drain_ctrl_vld && (state_q == ST_IDLE) && spill_s);

    case (state_q)
      ST_IDLE: begin
        busy_d   = 1'b0;
        wr_vld_d = 1'b0;
        if (lsu_mm_drain_ctrl_vld) begin
          state_d   = ST_RUN;
          row_len_d = lsu_mm_drain_ctrl_row_len;
          col_len_d = lsu_mm_drain_ctrl_col_len;
          start_d   = lsu_mm_drain_ctrl_start_addr;
          ptr_d     = 4'd0;
          busy_d    = 1'b1;
          clear_s   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (wr_vld_q) begin
          if (lsu_mm_drain_ram_write_rdy) begin
            if (ptr_q == row_len_q) begin
              state_d  = ST_DONE;
              wr_vld_d = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
            end else begin
              // Next row may already be complete: issue it back-to-back
              ptr_d      = ptr_q + 4'd1;
              load_idx_s = ptr_d;
              load_s     = row_done_s[ptr_d];
              wr_vld_d   = row_done_s[ptr_d];
            end
          end else begin
            wr_vld_d = 1'b1;
          end
        end else begin
          load_s   = row_done_s[ptr_q];
          wr_vld_d = row_done_s[ptr_q];
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        wr_vld_d = 1'b0;
      end
      default: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        wr_vld_d = 1'b0;
      end
    endcase

    if (load_s) begin
      wr_addr_d = start_q[BYTE_ADDR_W-1:4] + {4'b0000, load_idx_s};
      wr_data_d = align_row(pack_row_s[load_idx_s], start_q[3:0]);
      wr_mask_d = byte_mask(col_len_q, start_q[3:0]);
    end else begin
      wr_addr_d = wr_addr_q;
    end
  end

  // State, job configuration and write register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_len_q <= 4'd0;
      col_len_q <= 4'd0;
      start_q   <= '0;
      ptr_q     <= 4'd0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_mask_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_len_q <= row_len_d;
      col_len_q <= col_len_d;
      start_q   <= start_d;
      ptr_q     <= ptr_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_mask_q <= wr_mask_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign lsu_mm_drain_ram_write_vld  = wr_vld_q;
  assign lsu_mm_drain_ram_write_addr = wr_addr_q;
  assign lsu_mm_drain_ram_write_data = wr_data_q;
  assign lsu_mm_drain_ram_write_mask = wr_mask_q;
  assign lsu_mm_drain_busy           = busy_q;
  assign lsu_mm_drain_done           = done_q;
  assign lsu_mm_drain_err            = err_q;

endmodule

// File: tb/tb_mm_result_drain_buffer.sv
// Scoreboard bench for mm_result_drain_buffer: stimulus pushes expected RAM writes, a monitor checks them.
module tb_mm_result_drain_buffer;

  typedef struct {
    logic [7:0]   addr;
    logic [127:0] data;
    logic [15:0]  mask;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         ctrl_vld;
  logic [3:0]   ctrl_row_len;
  logic [3:0]   ctrl_col_len;
  logic [11:0]  ctrl_start;
  logic [15:0]  mxu_vld;
  logic [127:0] mxu_data;
  logic         wr_vld;
  logic         wr_rdy;
  logic [7:0]   wr_addr;
  logic [127:0] wr_data;
  logic [15:0]  wr_mask;
  logic         busy;
  logic         done;
  logic         err;

  wr_t        exp_q[$];
  logic [7:0] jb [16][16];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         err_seen = 0;
  int         done_seen = 0;
  int         hs_cnt = 0;
  int         last_hs_cyc = -10;
  logic         holding = 1'b0;
  logic [7:0]   hold_addr;
  logic [127:0] hold_data;
  logic [15:0]  hold_mask;

  mm_result_drain_buffer dut (
    .clk                          (clk),
    .rst                          (rst),
    .lsu_mm_drain_ctrl_vld        (ctrl_vld),
    .lsu_mm_drain_ctrl_row_len    (ctrl_row_len),
    .lsu_mm_drain_ctrl_col_len    (ctrl_col_len),
    .lsu_mm_drain_ctrl_start_addr (ctrl_start),
    .mxu_mm_drain_vld             (mxu_vld),
    .mxu_mm_drain_data            (mxu_data),
    .lsu_mm_drain_ram_write_vld   (wr_vld),
    .lsu_mm_drain_ram_write_rdy   (wr_rdy),
    .lsu_mm_drain_ram_write_addr  (wr_addr),
    .lsu_mm_drain_ram_write_data  (wr_data),
    .lsu_mm_drain_ram_write_mask  (wr_mask),
    .lsu_mm_drain_busy            (busy),
    .lsu_mm_drain_done            (done),
    .lsu_mm_drain_err             (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [7:0] relu(input logic [7:0] b);
`ifdef MM_DRAIN_RELU_EN
    return b[7] ? 8'h00 : b;
`else
    return b;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected lines: byte k of row r lands at byte lane off+k of line start[11:4]+r, dropped past lane 15
  task automatic push_expected(input logic [3:0] rl, input logic [3:0] cl, input logic [11:0] sa);
    wr_t e;
    int  p;
    for (int r = 0; r <= int'(rl); r++) begin
      e.addr = sa[11:4] + 8'(r);
      e.data = '0;
      e.mask = '0;
      for (int k = 0; k <= int'(cl); k++) begin
        p = int'(sa[3:0]) + k;
        if (p < 16) begin
          e.mask[p]        = 1'b1;
          e.data[p*8 +: 8] = relu(jb[r][k]);
        end
      end
      exp_q.push_back(e);
    end
  endtask

  // Start pulse then skewed lane traffic; inj5/injc place a stray lane-5 beat / a ctrl pulse at skew step t
  task automatic run_job(input logic [3:0] rl, input logic [3:0] cl, input logic [11:0] sa,
                         input int inj5, input int injc);
    int k;
    push_expected(rl, cl, sa);
    ctrl_vld = 1'b1; ctrl_row_len = rl; ctrl_col_len = cl; ctrl_start = sa;
    step();
    ctrl_vld = 1'b0;
    for (int t = 0; t <= int'(rl) + int'(cl); t++) begin
      mxu_vld = '0; mxu_data = '0;
      for (int i = 0; i <= int'(rl); i++) begin
        k = t - i;
        if (k >= 0 && k <= int'(cl)) begin
          mxu_vld[i]         = 1'b1;
          mxu_data[i*8 +: 8] = jb[i][k];
        end
      end
      if (t == inj5) begin
        mxu_vld[5] = 1'b1; mxu_data[47:40] = 8'hEE;
      end
      if (t == injc) begin
        ctrl_vld = 1'b1; ctrl_row_len = 4'd0; ctrl_col_len = 4'd0; ctrl_start = 12'h000;
      end
      step();
      ctrl_vld = 1'b0;
    end
    mxu_vld = '0; mxu_data = '0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    d0 = done_seen;
    for (int n = 0; n < 400; n++) begin
      if (done_seen > d0) break;
      step();
    end
    chk({name, "_done_seen"}, 128'(done_seen > d0), 128'(1));
    chk({name, "_queue_empty"}, 128'(exp_q.size()), 128'(0));
    step();
  endtask

  // Monitor: pulse counters, hold-stability under backpressure, scoreboard compare on each handshake
  always @(negedge clk) begin
    if (rst) begin
      holding = 1'b0;
    end else begin
      if (err) err_seen++;
      if (done) begin
        done_seen++;
        chk("done_latency", 128'(cyc), 128'(last_hs_cyc + 1));
      end
      if (holding) begin
        chk("hold_vld", 128'(wr_vld), 128'(1));
        chk("hold_addr", 128'(wr_addr), 128'(hold_addr));
        chk("hold_data", wr_data, hold_data);
        chk("hold_mask", 128'(wr_mask), 128'(hold_mask));
      end
      if (wr_vld && wr_rdy) begin
        holding = 1'b0;
        hs_cnt++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual addr=%h required no write", wr_addr);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 128'(wr_addr), 128'(e.addr));
          chk("wr_data", wr_data, e.data);
          chk("wr_mask", 128'(wr_mask), 128'(e.mask));
        end
      end else if (wr_vld) begin
        holding = 1'b1;
        hold_addr = wr_addr; hold_data = wr_data; hold_mask = wr_mask;
      end else begin
        holding = 1'b0;
      end
    end
  end

  initial begin
    int e0;
    rst = 1'b1; ctrl_vld = 1'b0; ctrl_row_len = '0; ctrl_col_len = '0; ctrl_start = '0;
    mxu_vld = '0; mxu_data = '0; wr_rdy = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_vld", 128'(wr_vld), 128'(0));
    chk("rst_addr", 128'(wr_addr), 128'(0));
    chk("rst_data", wr_data, 128'(0));
    chk("rst_mask", 128'(wr_mask), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    step();

    // Basic 4x4 at 0x100
    for (int i = 0; i < 16; i++) for (int k = 0; k < 16; k++) jb[i][k] = 8'(16 * i + k);
    e0 = err_seen;
    run_job(4'd3, 4'd3, 12'h100, -1, -1);
    chk("basic_busy", 128'(busy | done), 128'(1));
    wait_done("basic");
    chk("basic_err", 128'(err_seen - e0), 128'(0));
    chk("basic_idle_busy", 128'(busy), 128'(0));

    // Offset start 0x105, one row of three bytes
    jb[0][0] = 8'hA1; jb[0][1] = 8'hA2; jb[0][2] = 8'hA3;
    e0 = err_seen;
    run_job(4'd0, 4'd2, 12'h105, -1, -1);
    wait_done("offset");
    chk("offset_err", 128'(err_seen - e0), 128'(0));

    // Backpressure: rdy low for 5 cycles once row 0 has been accepted
    for (int i = 0; i < 16; i++) for (int k = 0; k < 16; k++) jb[i][k] = 8'(8'h40 + 4 * i + k);
    e0 = hs_cnt;
    fork
      run_job(4'd3, 4'd3, 12'h200, -1, -1);
      begin
        for (int n = 0; n < 200; n++) begin
          if (hs_cnt > e0) break;
          step();
        end
        wr_rdy = 1'b0;
        repeat (5) step();
        wr_rdy = 1'b1;
      end
    join
    wait_done("bp");
    chk("bp_writes", 128'(hs_cnt - e0), 128'(4));

    // Spill and address wrap at 0xFFE
    for (int i = 0; i < 16; i++) for (int k = 0; k < 16; k++) jb[i][k] = 8'(8'h60 + 4 * i + k);
    e0 = err_seen;
    run_job(4'd1, 4'd3, 12'hFFE, -1, -1);
    wait_done("spill");
    chk("spill_err", 128'(err_seen - e0), 128'(1));

    // Protocol errors: stray lane 5 and ctrl while busy, then lane traffic in IDLE
    for (int i = 0; i < 16; i++) for (int k = 0; k < 16; k++) jb[i][k] = 8'(8'h20 + 16 * i + k);
    e0 = err_seen;
    run_job(4'd3, 4'd3, 12'h100, 1, 3);
    wait_done("proto");
    chk("proto_err", 128'(err_seen - e0), 128'(2));
    step();
    e0 = err_seen;
    mxu_vld = 16'h0001; mxu_data = 128'h11;
    step();
    mxu_vld = '0; mxu_data = '0;
    step(); step();
    chk("idle_vld_err", 128'(err_seen - e0), 128'(1));
    chk("idle_vld_nowrite", 128'(wr_vld), 128'(0));

    // RELU behaviour on 0x80 / 0x7F
    jb[0][0] = 8'h80; jb[0][1] = 8'h7F;
    run_job(4'd0, 4'd1, 12'h300, -1, -1);
    wait_done("relu");

    // Reset in the middle of a job
    e0 = hs_cnt;
    ctrl_vld = 1'b1; ctrl_row_len = 4'd3; ctrl_col_len = 4'd3; ctrl_start = 12'h400;
    step();
    ctrl_vld = 1'b0;
    mxu_vld = 16'h0001; mxu_data = 128'h01;
    step();
    mxu_vld = 16'h0003; mxu_data = 128'h0202;
    step();
    chk("pre_rst_busy", 128'(busy), 128'(1));
    rst = 1'b1; mxu_vld = '0; mxu_data = '0;
    @(negedge clk);
    chk("mid_rst_vld", 128'(wr_vld), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_done", 128'(done), 128'(0));
    chk("mid_rst_err", 128'(err), 128'(0));
    chk("mid_rst_mask", 128'(wr_mask), 128'(0));
    step();
    rst = 1'b0;
    repeat (10) step();
    chk("post_rst_writes", 128'(hs_cnt - e0), 128'(0));
    chk("post_rst_busy", 128'(busy), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
